// File: rtl/rr_arbiter16_if.sv
// rr_arbiter16_if: request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface rr_arbiter16_if;
    logic        enable_i;
    logic [15:0] req_i;
    logic        release_i;
    logic [15:0] grant_o;
    logic [3:0]  grant_idx_o;
    logic        grant_valid_o;
    modport master (output enable_i, req_i, release_i, input grant_o, grant_idx_o, grant_valid_o);
    modport slave  (input enable_i, req_i, release_i, output grant_o, grant_idx_o, grant_valid_o);
endinterface

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with bounded hold time and registered one-hot/index grant.
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic         clk,
    input logic         rst_n,
    rr_arbiter16_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d, idx_q, idx_d, sel;
    logic [4:0]  hold_q, hold_d;
    logic [15:0] grant_q, grant_d;
    logic        valid_q, valid_d, found, term;
    // Walk offsets high to low so the lowest offset from ptr wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (bus.req_i[ptr_q + 4'(i)]) begin
                sel   = ptr_q + 4'(i);
                found = 1'b1;
            end
        end
    end
    assign term = bus.release_i | ~bus.req_i[idx_q] | ~bus.enable_i | (hold_q == 5'(MAX_HOLD - 1));
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (bus.enable_i && found) begin
                state_d = BUSY;
                idx_d   = sel;
                grant_d = 16'd1 << sel;
                valid_d = 1'b1;
                hold_d  = '0;
            end
            BUSY: if (term) begin
                state_d = IDLE;
                ptr_d   = idx_q + 4'd1;
                idx_d   = '0;
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end else begin
                hold_d  = hold_q + 5'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end
    assign bus.grant_o       = grant_q;
    assign bus.grant_idx_o   = idx_q;
    assign bus.grant_valid_o = valid_q;
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed-vector bench for rr_arbiter16 with hand-computed expectations.
module tb_rr_arbiter16;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    rr_arbiter16_if bus ();
    rr_arbiter16 #(.MAX_HOLD(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic v, input logic [3:0] idx, input logic [15:0] g);
        chk({tag, ".valid"}, 32'(bus.grant_valid_o), 32'(v));
        chk({tag, ".idx"},   32'(bus.grant_idx_o),   32'(idx));
        chk({tag, ".grant"}, 32'(bus.grant_o),       32'(g));
    endtask
    initial begin
        bus.enable_i  = 1'b0;
        bus.req_i     = '0;
        bus.release_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_out("reset", 1'b0, 4'd0, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
        // Basic grant then release hands over to the next requester
        bus.req_i = 16'h0011; bus.enable_i = 1'b1;
        tick(); chk_out("first", 1'b1, 4'd0, 16'h0001);
        bus.release_i = 1'b1;
        tick(); chk_out("rel_idle", 1'b0, 4'd0, 16'h0000);
        bus.release_i = 1'b0;
        tick(); chk_out("second", 1'b1, 4'd4, 16'h0010);
        bus.req_i = 16'h0000;
        tick(); chk_out("drop_idle", 1'b0, 4'd0, 16'h0000);
        // Pointer wrap from 15 to 0
        bus.req_i = 16'h8000;
        tick(); chk_out("g15", 1'b1, 4'd15, 16'h8000);
        bus.req_i = 16'h8001; bus.release_i = 1'b1;
        tick(); chk_out("g15_end", 1'b0, 4'd0, 16'h0000);
        bus.release_i = 1'b0;
        tick(); chk_out("wrap", 1'b1, 4'd0, 16'h0001);
        bus.req_i = 16'h0000;
        tick(); chk_out("wrap_end", 1'b0, 4'd0, 16'h0000);
        // Timeout after MAX_HOLD cycles, one idle cycle, then re-grant
        bus.req_i = 16'h0004;
        for (int i = 0; i < 8; i++) begin
            tick(); chk_out($sformatf("hold%0d", i), 1'b1, 4'd2, 16'h0004);
        end
        tick(); chk_out("timeout_idle", 1'b0, 4'd0, 16'h0000);
        tick(); chk_out("regrant", 1'b1, 4'd2, 16'h0004);
        bus.req_i = 16'h0000;
        tick(); chk_out("regrant_end", 1'b0, 4'd0, 16'h0000);
        // Owner drop; other request changes ignored while busy
        bus.req_i = 16'h0008;
        tick(); chk_out("g3", 1'b1, 4'd3, 16'h0008);
        bus.req_i = 16'h0018;
        tick(); chk_out("g3_stable", 1'b1, 4'd3, 16'h0008);
        bus.req_i = 16'h0100;
        tick(); chk_out("g3_drop", 1'b0, 4'd0, 16'h0000);
        tick(); chk_out("g8", 1'b1, 4'd8, 16'h0100);
        // Enable low kills the grant and blocks new ones
        bus.enable_i = 1'b0;
        tick(); chk_out("en_off", 1'b0, 4'd0, 16'h0000);
        bus.req_i = 16'hFFFF;
        tick(); chk_out("en_off_ffff0", 1'b0, 4'd0, 16'h0000);
        tick(); chk_out("en_off_ffff1", 1'b0, 4'd0, 16'h0000);
        bus.enable_i = 1'b1;
        tick(); chk_out("en_on", 1'b1, 4'd9, 16'h0200);
        // Async reset while idx 7 owns the grant
        bus.req_i = 16'h0080;
        tick(); chk_out("g9_drop", 1'b0, 4'd0, 16'h0000);
        tick(); chk_out("g7", 1'b1, 4'd7, 16'h0080);
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 1'b0, 4'd0, 16'h0000);
        tick();
        rst_n = 1'b1;
        bus.req_i = 16'h0081;
        tick(); chk_out("post_rst", 1'b1, 4'd0, 16'h0001);
        // Release coincident with owner drop advances ptr once
        bus.req_i = 16'h0002; bus.release_i = 1'b1;
        tick(); chk_out("dual_term", 1'b0, 4'd0, 16'h0000);
        bus.req_i = 16'h0003; bus.release_i = 1'b0;
        tick(); chk_out("single_adv", 1'b1, 4'd1, 16'h0002);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL provide parameter: MAX_HOLD, 8, maximum consecutive cycles one grant is held (legal range 1..16).
REQ-002 SHALL provide port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: enable  input  1  arbitration enable; low forces no new grants and terminates any active grant.
REQ-005 SHALL provide port: req  input  16  per-requester request, bit i = requester i, level-sensitive.
REQ-006 SHALL provide port: release  input  1  current owner done; ends active grant.
REQ-007 SHALL provide port: grant  output  16  one-hot grant vector, all-zero when no grant.
REQ-008 SHALL provide port: grant_idx  output  4  binary index of granted requester, 0 when no grant.
REQ-009 SHALL provide port: grant_valid  output  1  high while a grant is active.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and BUSY (grant held); all outputs registered.
REQ-011 SHALL keep a 4-bit round-robin pointer ptr; search order ptr, ptr+1, ..., ptr+15 modulo 16.
REQ-012 In IDLE with enable=1 and req!=0, SHALL select the first set req bit in search order and enter BUSY at the next edge with grant, grant_idx, grant_valid updated; latency one cycle from req to grant.
REQ-013 In IDLE with enable=0 or req=0, SHALL remain IDLE, outputs zero.
REQ-014 In BUSY, grant/grant_idx SHALL remain stable until termination; changes on other req bits SHALL be ignored.
REQ-015 BUSY SHALL terminate at the next edge when any holds: release=1, req[grant_idx]=0, enable=0, or hold counter equals MAX_HOLD-1.
REQ-016 Hold counter (5 bits) SHALL clear on entry to BUSY and increment each BUSY cycle not terminating; owner therefore holds at most MAX_HOLD cycles.
REQ-017 On termination SHALL set ptr = grant_idx+1 modulo 16 (15 wraps to 0), clear all outputs, and enter IDLE; at least one idle cycle separates consecutive grants.
REQ-018 release or req changes while in IDLE SHALL have no effect beyond REQ-012 selection; release in IDLE ignored.
REQ-019 Simultaneous release and req[grant_idx] drop SHALL be treated as one termination; ptr advance occurs once.
REQ-020 grant SHALL always equal one-hot decode of grant_idx when grant_valid=1, else 16'h0000; never more than one bit set.

Reset
REQ-021 rst_n=0 SHALL immediately, without clock, force state=IDLE, ptr=0, hold counter=0, grant=16'h0000, grant_idx=0, grant_valid=0.
REQ-022 Reset asserted mid-grant SHALL drop the grant asynchronously; after deassertion arbitration restarts from ptr=0.
REQ-023 First rising clk edge after rst_n deassertion SHALL be permitted to issue a grant.

Verification
REQ-024 Reset then req=16'h0011, enable=1 -> next edge grant=16'h0001, grant_idx=0; release pulse -> IDLE, then grant=16'h0010, grant_idx=4.
REQ-025 ptr wrap: grant to idx 15 ended by release, req=16'h8001 held -> next grant idx 0, not 15.
REQ-026 Timeout: MAX_HOLD=8, req=16'h0004 held, no release -> grant_valid high exactly 8 cycles, one idle cycle, re-granted idx 2.
REQ-027 Owner drop: granted idx 3, req changes 16'h0008->16'h0100 -> grant ends next edge, after idle cycle grant_idx=8; req changes during BUSY do not alter grant.
REQ-028 enable low in BUSY -> outputs zero next edge; enable low with req=16'hFFFF -> grant_valid stays 0.
REQ-029 rst_n pulsed low while grant_idx=7 active -> outputs zero without clock edge; after release of reset, req=16'h0081 -> grant_idx=0.
